elevator_request_latch: RTL and testbench
=========================================

# elevator_request_latch

Request front end for the `elevator2` controller. Turns raw momentary floor keys into the persistent 10-bit `buttons` request vector that `elevator2` consumes. Each key press toggles its request, so a second press cancels it. Feeds the `Layer` floor output of `elevator2` back in so that a request is cleared automatically once the car has held at that floor for a dwell period, with a door-open indication.

## Interface
Parameters:
- FLOORS, 10: number of floors / request bits (floors 0..FLOORS-1).
- DWELL, 4: cycles the car must hold on a requested floor before the request clears; also the door-open duration. Legal range 2..15.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (Reset=0 resets immediately; release synchronous to CLK is the integrator's job).
- key_in  in  FLOORS  raw momentary floor keys, asynchronous to CLK, active-high.
- Layer  in  4  current floor from `elevator2`.
- buttons  out  FLOORS  registered pending-request vector to `elevator2`; bit i = floor i requested.
- door_open  out  1  registered; high while in OPEN.
- arrived  out  1  registered one-cycle pulse when a request is served.

## Operation
- Input path, per bit: two-flop synchronizer s1→s2, then s3 <= s2. rise[i] = s2[i] & ~s3[i]. A key held high produces exactly one rise.
- Toggle: on rise[i], buttons[i] <= ~buttons[i], except in the case noted below for OPEN. All bits update independently in the same cycle.
- Floor tracking: layer_q <= Layer every cycle. hit = (Layer == layer_q) && (Layer < FLOORS) && buttons[Layer]. Layer ≥ FLOORS never matches and never clears anything.
- FSM states are IDLE, COUNT and OPEN. A 4-bit counter cnt is used.
  - IDLE: door_open=0. If hit → COUNT, cnt<=0.
  - COUNT: if Layer != layer_q or buttons[Layer]=0 (cancelled) → IDLE.
    - Else if cnt == DWELL-1 → OPEN. In the same edge: buttons[Layer]<=0, arrived<=1, cnt<=0.
    - Else cnt<=cnt+1.
  - OPEN: door_open=1.
    - rise on bit Layer is ignored (the door is open at that floor). Other bits toggle normally.
    - cnt == DWELL-1 → IDLE, else cnt<=cnt+1.
    - A Layer change while in OPEN does not abort the state. OPEN always runs DWELL cycles.
- Simultaneous events: if the clear and a rise hit the same bit in the same edge, the clear wins (bit = 0). A rise on any other bit in that edge is applied.
- arrived is high for exactly the one cycle following the COUNT→OPEN edge, then returns to 0.
- A re-press on the current floor after OPEN→IDLE sets the request again. It is served again after a further DWELL cycles in COUNT.
- Reset (async, mid-operation included) forces all of the following to 0, with FSM=IDLE:
  - s1, s2, s3
  - buttons
  - layer_q
  - cnt
  - door_open
  - arrived
  
  Presses in flight are lost.

## Timing
- Key to buttons latency: key_in high before edge k → s1 at k, s2 at k+1, buttons toggles at edge k+2. The bit is visible 3 rising edges after the key rises.
- Service latency:
  - Layer stable on a requested floor, with layer_q matching, from edge j (IDLE→COUNT at j).
  - buttons bit clears and door_open/arrived rise at edge j+DWELL.
  - door_open falls at edge j+2·DWELL.
- All outputs are registered. There is no combinational path from key_in or Layer to any output.

## Test plan
- Reset: Reset=0 with random key_in/Layer → buttons=10'b0, door_open=0, arrived=0. Release, then key_in=10'b0000000110 for 1 cycle → buttons=10'b0000000110 after 3 edges.
- Cancel and held key: press key 1 again → buttons=10'b0000000100. Hold key 7 for 20 cycles → bit 7 toggles once only (buttons=10'b0010000100).
- Arrival clear, DWELL=4:
  - Request floor 8, drive Layer=8 steady.
  - Exactly 4 edges after IDLE→COUNT: bit 8 clears and arrived pulses 1 cycle.
  - door_open stays high 4 cycles.
- Pass-through and abort: request 9, Layer steps 7,8,9 one cycle each, then holds 9 → no clear until 9 is held DWELL cycles. Layer leaving 9 at cnt=2 → back to IDLE, bit 9 still set.
- Collision:
  - Press key 4 on the same edge that floor 4 clears → bit 4=0.
  - Press key 4 during OPEN at floor 4 → ignored.
  - Press key 0 during OPEN → bit 0 set.
- Out of range and async reset: Layer=4'd12 with all requests set → nothing clears. Assert Reset mid-COUNT → immediate zeros and IDLE.

Source files
------------

// File: rtl/elevator_request_latch.sv
// Floor-request front end: synchronises momentary keys into toggling request bits
// and clears a request once the car has dwelt on that floor, opening the door.
module elevator_request_latch #(
    parameter int FLOORS = 10,
    parameter int DWELL  = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [FLOORS-1:0] key_in,
    input  logic [3:0]        Layer,
    output logic [FLOORS-1:0] buttons,
    output logic              door_open,
    output logic              arrived
);

    typedef enum logic [1:0] {IDLE, COUNT, OPEN} state_t;

    localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

    logic [FLOORS-1:0] s1, s2, s3;
    logic [FLOORS-1:0] rise;
    logic [FLOORS-1:0] floor_mask;
    logic [FLOORS-1:0] clear_mask;
    logic [FLOORS-1:0] ignore_mask;
    logic [FLOORS-1:0] buttons_nxt;
    logic [3:0]        layer_q;
    logic [3:0]        cnt, cnt_nxt;
    logic              layer_stable;
    logic              floor_req;
    logic              arrive_nxt;
    state_t            state, state_nxt;

    // Key synchroniser and edge detect
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= key_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // An out-of-range floor shifts the one-hot bit off the top, so it never matches.
    assign floor_mask   = FLOORS'(1) << Layer;
    assign layer_stable = (Layer == layer_q);
    assign floor_req    = |(buttons & floor_mask);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        clear_mask  = '0;
        ignore_mask = '0;
        arrive_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (layer_stable && floor_req) begin
                    state_nxt = COUNT;
                    cnt_nxt   = 4'd0;
                end
            end
            COUNT: begin
                if (!layer_stable || !floor_req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = OPEN;
                    clear_mask = floor_mask;
                    arrive_nxt = 1'b1;
                    cnt_nxt    = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            OPEN: begin
                ignore_mask = floor_mask;
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Clear is applied after the toggle so it wins a same-edge collision.
    assign buttons_nxt = (buttons ^ (rise & ~ignore_mask)) & ~clear_mask;

    // Registered request vector, floor tracker and FSM
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            buttons   <= '0;
            layer_q   <= 4'd0;
            door_open <= 1'b0;
            arrived   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            buttons   <= buttons_nxt;
            layer_q   <= Layer;
            door_open <= (state_nxt == OPEN);
            arrived   <= arrive_nxt;
        end
    end

endmodule

// File: tb/tb_elevator_request_latch.sv
// Table-driven, scoreboarded bench for elevator_request_latch (FLOORS=10, DWELL=4).
module tb_elevator_request_latch;

    logic       CLK;
    logic       Reset;
    logic [9:0] key_in;
    logic [3:0] Layer;
    logic [9:0] buttons;
    logic       door_open;
    logic       arrived;

    int checks;
    int errors;

    elevator_request_latch #(.FLOORS(10), .DWELL(4)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .key_in   (key_in),
        .Layer    (Layer),
        .buttons  (buttons),
        .door_open(door_open),
        .arrived  (arrived)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic [9:0] key;
        logic [3:0] layer;
        int         reps;
        logic [9:0] btn;
        logic       door;
        logic       arr;
    } vec_t;

    typedef struct {
        logic       chk;
        logic [9:0] btn;
        logic       door;
        logic       arr;
        int         id;
    } exp_t;

    vec_t vecs[54];
    exp_t sb[$];

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step%0d: got %h expected %h", name, id, act, req);
        end
    endtask

    // One cycle per repetition; expected values are checked on the last one.
    task automatic step(input logic rst_n, input logic [9:0] key, input logic [3:0] lay, input int reps,
                        input logic [9:0] eb, input logic ed, input logic ea, input int id);
        exp_t e;
        for (int r = 0; r < reps; r++) begin
            @(negedge CLK);
            Reset  = rst_n;
            key_in = key;
            Layer  = lay;
            e.chk  = (r == reps - 1);
            e.btn  = eb;
            e.door = ed;
            e.arr  = ea;
            e.id   = id;
            sb.push_back(e);
            @(posedge CLK);
            #1;
            if (sb.size() == 0) begin
                check("scoreboard_empty", id, 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    check("buttons", e.id, 32'(buttons), 32'(e.btn));
                    check("door_open", e.id, 32'(door_open), 32'(e.door));
                    check("arrived", e.id, 32'(arrived), 32'(e.arr));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b0;
        key_in = 10'h3FF;
        Layer  = 4'd5;

        //            rst  key     layer reps btn     door arr
        vecs[0]  = '{1'b0, 10'h3FF, 4'd5,  3, 10'h000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 10'h000, 4'd15, 2, 10'h000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 10'h006, 4'd15, 1, 10'h000, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 10'h000, 4'd15, 1, 10'h000, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 10'h000, 4'd15, 1, 10'h006, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 10'h000, 4'd15, 2, 10'h006, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 10'h002, 4'd15, 1, 10'h006, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 10'h000, 4'd15, 1, 10'h006, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 10'h000, 4'd15, 1, 10'h004, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 10'h080, 4'd15, 20, 10'h084, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 10'h000, 4'd15, 3, 10'h084, 1'b0, 1'b0};
        // request floor 8 and serve it
        vecs[11] = '{1'b1, 10'h100, 4'd15, 1, 10'h084, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 10'h000, 4'd15, 1, 10'h084, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 10'h000, 4'd15, 1, 10'h184, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 10'h000, 4'd8,  1, 10'h184, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 10'h000, 4'd8,  1, 10'h184, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 10'h000, 4'd8,  3, 10'h184, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 10'h000, 4'd8,  1, 10'h084, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 10'h000, 4'd8,  1, 10'h084, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 10'h000, 4'd8,  2, 10'h084, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 10'h000, 4'd8,  1, 10'h084, 1'b0, 1'b0};
        // floor 9: pass-through, abort at cnt=2, then full service
        vecs[21] = '{1'b1, 10'h200, 4'd15, 1, 10'h084, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 10'h000, 4'd15, 1, 10'h084, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 10'h000, 4'd15, 1, 10'h284, 1'b0, 1'b0};
        vecs[24] = '{1'b1, 10'h000, 4'd7,  1, 10'h284, 1'b0, 1'b0};
        vecs[25] = '{1'b1, 10'h000, 4'd8,  1, 10'h284, 1'b0, 1'b0};
        vecs[26] = '{1'b1, 10'h000, 4'd9,  1, 10'h284, 1'b0, 1'b0};
        vecs[27] = '{1'b1, 10'h000, 4'd9,  1, 10'h284, 1'b0, 1'b0};
        vecs[28] = '{1'b1, 10'h000, 4'd9,  2, 10'h284, 1'b0, 1'b0};
        vecs[29] = '{1'b1, 10'h000, 4'd8,  1, 10'h284, 1'b0, 1'b0};
        vecs[30] = '{1'b1, 10'h000, 4'd9,  1, 10'h284, 1'b0, 1'b0};
        vecs[31] = '{1'b1, 10'h000, 4'd9,  1, 10'h284, 1'b0, 1'b0};
        vecs[32] = '{1'b1, 10'h000, 4'd9,  3, 10'h284, 1'b0, 1'b0};
        vecs[33] = '{1'b1, 10'h000, 4'd9,  1, 10'h084, 1'b1, 1'b1};
        vecs[34] = '{1'b1, 10'h000, 4'd9,  3, 10'h084, 1'b1, 1'b0};
        vecs[35] = '{1'b1, 10'h000, 4'd9,  1, 10'h084, 1'b0, 1'b0};
        // floor 4: press collides with clear, presses during OPEN
        vecs[36] = '{1'b1, 10'h010, 4'd15, 1, 10'h084, 1'b0, 1'b0};
        vecs[37] = '{1'b1, 10'h000, 4'd15, 2, 10'h094, 1'b0, 1'b0};
        vecs[38] = '{1'b1, 10'h000, 4'd4,  1, 10'h094, 1'b0, 1'b0};
        vecs[39] = '{1'b1, 10'h000, 4'd4,  1, 10'h094, 1'b0, 1'b0};
        vecs[40] = '{1'b1, 10'h000, 4'd4,  1, 10'h094, 1'b0, 1'b0};
        vecs[41] = '{1'b1, 10'h010, 4'd4,  1, 10'h094, 1'b0, 1'b0};
        vecs[42] = '{1'b1, 10'h000, 4'd4,  1, 10'h094, 1'b0, 1'b0};
        vecs[43] = '{1'b1, 10'h000, 4'd4,  1, 10'h084, 1'b1, 1'b1};
        vecs[44] = '{1'b1, 10'h011, 4'd4,  1, 10'h084, 1'b1, 1'b0};
        vecs[45] = '{1'b1, 10'h000, 4'd4,  1, 10'h084, 1'b1, 1'b0};
        vecs[46] = '{1'b1, 10'h000, 4'd4,  1, 10'h085, 1'b1, 1'b0};
        vecs[47] = '{1'b1, 10'h000, 4'd4,  1, 10'h085, 1'b0, 1'b0};
        vecs[48] = '{1'b1, 10'h000, 4'd4,  2, 10'h085, 1'b0, 1'b0};
        // all requests set, out-of-range floor, then enter COUNT at floor 3
        vecs[49] = '{1'b1, 10'h37A, 4'd12, 1, 10'h085, 1'b0, 1'b0};
        vecs[50] = '{1'b1, 10'h000, 4'd12, 2, 10'h3FF, 1'b0, 1'b0};
        vecs[51] = '{1'b1, 10'h000, 4'd12, 10, 10'h3FF, 1'b0, 1'b0};
        vecs[52] = '{1'b1, 10'h000, 4'd3,  2, 10'h3FF, 1'b0, 1'b0};
        vecs[53] = '{1'b1, 10'h000, 4'd3,  1, 10'h3FF, 1'b0, 1'b0};

        #2;
        check("reset_buttons", -1, 32'(buttons), 32'd0);

        for (int i = 0; i < 54; i++) begin
            step(vecs[i].rst_n, vecs[i].key, vecs[i].layer, vecs[i].reps,
                 vecs[i].btn, vecs[i].door, vecs[i].arr, i);
        end

        // Asynchronous reset mid-COUNT, away from any clock edge
        #2;
        Reset  = 1'b0;
        key_in = 10'($urandom);
        #1;
        check("async_buttons", 100, 32'(buttons), 32'd0);
        check("async_door", 100, 32'(door_open), 32'd0);
        check("async_arrived", 100, 32'(arrived), 32'd0);

        // Recovery from reset, service of floor 3, then a re-press at the same floor
        step(1'b0, 10'h000, 4'd3, 1, 10'h000, 1'b0, 1'b0, 101);
        step(1'b1, 10'h000, 4'd3, 1, 10'h000, 1'b0, 1'b0, 102);
        step(1'b1, 10'h008, 4'd3, 1, 10'h000, 1'b0, 1'b0, 103);
        step(1'b1, 10'h000, 4'd3, 1, 10'h000, 1'b0, 1'b0, 104);
        step(1'b1, 10'h000, 4'd3, 1, 10'h008, 1'b0, 1'b0, 105);
        step(1'b1, 10'h000, 4'd3, 1, 10'h008, 1'b0, 1'b0, 106);
        step(1'b1, 10'h000, 4'd3, 3, 10'h008, 1'b0, 1'b0, 107);
        step(1'b1, 10'h000, 4'd3, 1, 10'h000, 1'b1, 1'b1, 108);
        step(1'b1, 10'h000, 4'd3, 3, 10'h000, 1'b1, 1'b0, 109);
        step(1'b1, 10'h000, 4'd3, 1, 10'h000, 1'b0, 1'b0, 110);
        step(1'b1, 10'h008, 4'd3, 1, 10'h000, 1'b0, 1'b0, 111);
        step(1'b1, 10'h000, 4'd3, 1, 10'h000, 1'b0, 1'b0, 112);
        step(1'b1, 10'h000, 4'd3, 1, 10'h008, 1'b0, 1'b0, 113);
        step(1'b1, 10'h000, 4'd3, 1, 10'h008, 1'b0, 1'b0, 114);
        step(1'b1, 10'h000, 4'd3, 3, 10'h008, 1'b0, 1'b0, 115);
        step(1'b1, 10'h000, 4'd3, 1, 10'h000, 1'b1, 1'b1, 116);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
